// File: rtl/siggen_pkg.sv
// Shared widths and types for the signal generator datapath.
package siggen_pkg;
  localparam int ADDR_WIDTH_DEF = 9;
  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic {
    FILLING = 1'b0,
    FULL    = 1'b1
  } delay_state_t;
endpackage

// File: rtl/ram2port.sv
// Simple dual-port RAM: synchronous write, registered synchronous read.
// Read data holds while rd_en is low; contents are not cleared by reset.
module ram2port import siggen_pkg::*; #(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/sample_delay.sv
// Programmable circular-buffer delay line: returns the sample captured `offset`
// strobes earlier, zero/invalid until that sample exists since reset.
module sample_delay import siggen_pkg::*; #(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] offset,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid
);
  localparam logic [ADDR_WIDTH-1:0] FILL_MAX  = '1;
  localparam logic [ADDR_WIDTH-1:0] FILL_LAST = {{(ADDR_WIDTH-1){1'b1}}, 1'b0};

  delay_state_t          state, next_state;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] fill;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] ram_q;
  logic [DATA_WIDTH-1:0] byp_q;
  logic                  byp_sel_q;
  logic                  valid_q;
  logic                  bypass;
  logic                  hit;

  assign bypass  = (offset == '0);
  assign rd_addr = wr_ptr - offset;
  // fill is sampled before this strobe's increment, i.e. fill == k until saturation
  assign hit     = (state == FULL) || (fill >= offset);

  ram2port #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (en),
    .wr_addr (wr_ptr),
    .wr_data (din),
    .rd_en   (en && !bypass),
    .rd_addr (rd_addr),
    .rd_data (ram_q)
  );

  always_comb begin
    next_state = state;
    if (state == FILLING && en && fill == FILL_LAST) next_state = FULL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FILLING;
      wr_ptr    <= '0;
      fill      <= '0;
      valid_q   <= 1'b0;
      byp_sel_q <= 1'b0;
      byp_q     <= '0;
    end else begin
      state <= next_state;
      if (en) begin
        wr_ptr    <= wr_ptr + 1'b1;
        if (fill != FILL_MAX) fill <= fill + 1'b1;
        valid_q   <= hit;
        byp_sel_q <= bypass;
        if (bypass) byp_q <= din;
      end
    end
  end

  // Output mux is driven only by flops, so dout still changes only on strobe edges or reset.
  assign dout_valid = valid_q;
  assign dout       = !valid_q ? '0 : (byp_sel_q ? byp_q : ram_q);
endmodule

// File: tb/tb_sample_delay.sv
// Directed-vector bench for sample_delay at ADDR_WIDTH=4, DATA_WIDTH=8.
module tb_sample_delay;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [3:0] offset = '0;
  logic [7:0] din = '0;
  logic [7:0] dout;
  logic       dout_valid;

  int n_vec = 0;
  int n_bad = 0;

  sample_delay #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .offset     (offset),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic strobe(input logic [7:0] d, input logic [3:0] off);
    @(negedge clk);
    en = 1'b1;
    din = d;
    offset = off;
    @(posedge clk);
    #1;
    en = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input int d, input int v);
    check({tag, ".dout"}, int'(dout), d);
    check({tag, ".valid"}, int'(dout_valid), v);
  endtask

  initial begin
    int exp_d [5];
    int exp_v [5];
    exp_d = '{0, 0, 0, 1, 2};
    exp_v = '{0, 0, 0, 1, 1};

    // reset state
    do_reset();
    expect_out("reset", 0, 0);

    // scenario 1: offset 3 fill-up
    for (int i = 0; i < 5; i++) begin
      strobe(8'(i + 1), 4'd3);
      expect_out($sformatf("s1.k%0d", i), exp_d[i], exp_v[i]);
    end

    // scenario 2: bypass
    do_reset();
    strobe(8'd7, 4'd0);
    expect_out("s2.k0", 7, 1);
    strobe(8'd9, 4'd0);
    expect_out("s2.k1", 9, 1);

    // scenario 3: maximum offset across pointer wrap
    do_reset();
    for (int k = 0; k < 40; k++) begin
      strobe(8'(k), 4'd15);
      if (k >= 15) expect_out($sformatf("s3.k%0d", k), k - 15, 1);
      else         expect_out($sformatf("s3.k%0d", k), 0, 0);
    end

    // scenario 4: gapped strobes, delay counted in strobes
    do_reset();
    strobe(8'd10, 4'd2);
    expect_out("s4.st0", 0, 0);
    idle();
    expect_out("s4.idle0", 0, 0);
    strobe(8'd20, 4'd2);
    expect_out("s4.st1", 0, 0);
    idle();
    expect_out("s4.idle1", 0, 0);
    strobe(8'd30, 4'd2);
    expect_out("s4.st2", 10, 1);
    idle();
    idle();
    expect_out("s4.hold", 10, 1);

    // scenario 5: offset raised while filling drops validity
    do_reset();
    for (int k = 0; k < 5; k++) strobe(8'(k), 4'd3);
    expect_out("s5.k4", 1, 1);
    for (int k = 5; k < 8; k++) begin
      strobe(8'(k), 4'd8);
      expect_out($sformatf("s5.k%0d", k), 0, 0);
    end
    strobe(8'd8, 4'd8);
    expect_out("s5.k8", 0, 1);
    strobe(8'd9, 4'd8);
    expect_out("s5.k9", 1, 1);

    // scenario 6: async reset mid-stream, stale RAM must not leak
    do_reset();
    for (int k = 0; k < 20; k++) strobe(8'(k + 1), 4'd1);
    expect_out("s6.pre", 19, 1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    expect_out("s6.async", 0, 0);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      strobe(8'(k + 50), 4'd4);
      if (k >= 4) expect_out($sformatf("s6.k%0d", k), k + 46, 1);
      else        expect_out($sformatf("s6.k%0d", k), 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
